jerry_ctl: RTL
==============

# jerry_ctl

Per-frame motion controller for the Jerry sprite: turns synchronised left/right/jump levels into the `jerry_x`/`jerry_y` position that the Jerry draw stage consumes. It runs a ground/rise/fall jump state machine with integer gravity and clamps horizontal travel to the play field. Position changes once per frame, at vertical blanking, so the sprite never tears mid-scan.

## Interface
Parameters:
- `X_INIT`, 100: x loaded at reset and respawn.
- `X_MIN`, 0: leftmost x.
- `X_MAX`, 760: rightmost x.
- `Y_FLOOR`, 500: ground y, and the y loaded at reset and respawn. Larger y is lower on screen.
- `Y_MIN`, 0: ceiling y.
- `STEP`, 4: horizontal pixels per frame.
- `JUMP_V0`, 12: initial upward speed, in px/frame.
- `GRAVITY`, 1: speed change per frame.
- `VMAX`, 15: terminal fall speed.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: asynchronous, active-low reset.
- `vblnk` in 1: vertical blank from the timing chain.
- `en` in 1: game running. When 0, position and state are frozen.
- `respawn` in 1: synchronous single-cycle reload request.
- `left`, `right`, `jump` in 1 each: synchronised, debounced levels.
- `jerry_x` out 10: sprite left edge.
- `jerry_y` out 10: sprite top edge.
- `facing` out 1: 0 = right, 1 = left.
- `airborne` out 1: high in RISE or FALL.

## Operation
- Frame tick: `tick = vblnk & ~vblnk_q`, where `vblnk_q` is `vblnk` registered. Exactly one tick per frame.
- All updates happen only on a tick with `en`=1. Otherwise every register holds, except `vblnk_q`, which always samples.
- Horizontal, evaluated on every tick:
  - `left` & !`right`: x = max(x−STEP, X_MIN), and `facing` = 1.
  - `right` & !`left`: x = min(x+STEP, X_MAX), and `facing` = 0.
  - Both or neither: x holds and `facing` holds.
- Vertical FSM, holding state and `vel` (unsigned 5-bit):
  - GROUND: y = Y_FLOOR. If `jump`=1, go to RISE with vel = JUMP_V0 and no y change this tick.
  - RISE: y_n = y − vel.
    - If y_n < Y_MIN: y = Y_MIN, go to FALL with vel = 0.
    - Else y = y_n. If vel ≤ GRAVITY, go to FALL with vel = 0. Else vel −= GRAVITY.
  - FALL: v_n = min(vel+GRAVITY, VMAX).
    - If y+v_n ≥ Y_FLOOR: y = Y_FLOOR, go to GROUND with vel = 0.
    - Else y += v_n and vel = v_n.
- `jump` is level-sensitive and sampled only in GROUND. `jump` while airborne is ignored. Holding `jump` re-launches on the first tick after landing.
- Horizontal and vertical updates apply on the same tick, independently.
- Arithmetic is done in 11-bit signed, so clamp comparisons never wrap. Registered x/y stay in [X_MIN, X_MAX] and [Y_MIN, Y_FLOOR].
- `respawn`=1 on any cycle sets x = X_INIT, y = Y_FLOOR, state = GROUND, vel = 0, facing = 0. It takes effect regardless of `en` and `tick`, and wins over a simultaneous tick.
- `rst` low at any time, including mid-jump: immediate return to the respawn values. `vblnk_q` is cleared to 0.

## Timing
- Reset values: `jerry_x` = X_INIT, `jerry_y` = Y_FLOOR, `facing` = 0, `airborne` = 0, state = GROUND.
- Outputs are registered and update on the clock edge that first samples `vblnk`=1. Latency from the vblnk rise is 1 edge.
- Inputs are sampled on that same edge only. Levels between ticks have no effect.
- `respawn` takes effect on the edge that samples it.
- `airborne` is decoded from the registered state and changes on the same edge as the state.
- If `vblnk` is already high when reset is released, the first edge produces a tick, because `vblnk_q` resets to 0.
- No combinational paths from inputs to outputs.

## Test plan
- Reset, then 3 frames with no input: x = 100, y = 500, `airborne` = 0 throughout. Assert `rst` low mid-frame: outputs return to reset values asynchronously.
- `right` held for 200 frames: x steps 100, 104, … up to 760, then stays at 760 with `facing` = 0. `left` held: x goes down to 0 and stays, with `facing` = 1. `left`+`right` together: x and `facing` unchanged.
- `jump` for one frame, defaults: 12 RISE ticks (y 488, 477, … 422), then 12 FALL ticks (y 423, 425, … 500). Land exactly at 500 on tick 24. `airborne` is high from tick 1 through tick 23.
- `jump` pulsed again during RISE and FALL: trajectory identical to the previous test. `jump` held continuously: the next launch starts on the tick after landing.
- `en` = 0 mid-jump for 5 frames: y, vel and state are frozen. After `en` = 1 the jump resumes from the same point.
- `respawn` on the same cycle as a tick, mid-jump at x = 300: next outputs are x = 100, y = 500, GROUND, `facing` = 0. With Y_MIN = 450 and a jump: y is clamped to 450, then falls from vel 0.

Source files
------------

// File: rtl/jerry_ctl.sv
// Per-frame motion controller for the Jerry sprite: horizontal stepping with play-field
// clamps plus a ground/rise/fall jump machine, all advanced once per frame at vblank rise.
module jerry_ctl #(
  parameter int X_INIT  = 100,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 760,
  parameter int Y_FLOOR = 500,
  parameter int Y_MIN   = 0,
  parameter int STEP    = 4,
  parameter int JUMP_V0 = 12,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       en,
  input  logic       respawn,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  output logic [9:0] jerry_x,
  output logic [9:0] jerry_y,
  output logic       facing,
  output logic       airborne,
  output logic [1:0] dbg_state,
  output logic [4:0] dbg_vel
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_e;

  // Signed 11-bit copies of the bounds so clamp compares see negatives instead of wrapping.
  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] YMIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] YFLOOR_S = 11'(Y_FLOOR);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [9:0]         X_INIT_V  = 10'(X_INIT);
  localparam logic [9:0]         X_MIN_V   = 10'(X_MIN);
  localparam logic [9:0]         X_MAX_V   = 10'(X_MAX);
  localparam logic [9:0]         Y_MIN_V   = 10'(Y_MIN);
  localparam logic [9:0]         Y_FLOOR_V = 10'(Y_FLOOR);
  localparam logic [4:0]         V0_V      = 5'(JUMP_V0);
  localparam logic [4:0]         G_V       = 5'(GRAVITY);
  localparam logic [4:0]         VMAX_V    = 5'(VMAX);

  logic              vblnk_q;
  logic              tick;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              facing_q, facing_d;
  state_e            state_q, state_d;
  logic [4:0]        vel_q, vel_d;
  logic signed [10:0] x_s, y_s, x_n, y_n;
  logic [5:0]        v_sum;
  logic [4:0]        v_n;

  always_comb begin
    tick     = vblnk & ~vblnk_q;
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    state_d  = state_q;
    vel_d    = vel_q;
    x_s      = signed'({1'b0, x_q});
    y_s      = signed'({1'b0, y_q});
    x_n      = x_s;
    y_n      = y_s;
    v_sum    = {1'b0, vel_q} + {1'b0, G_V};
    v_n      = (v_sum > {1'b0, VMAX_V}) ? VMAX_V : v_sum[4:0];

    if (left && !right) begin
      x_n      = x_s - STEP_S;
      x_d      = (x_n < XMIN_S) ? X_MIN_V : x_n[9:0];
      facing_d = 1'b1;
    end else if (right && !left) begin
      x_n      = x_s + STEP_S;
      x_d      = (x_n > XMAX_S) ? X_MAX_V : x_n[9:0];
      facing_d = 1'b0;
    end

    case (state_q)
      GROUND: begin
        y_d   = Y_FLOOR_V;
        vel_d = '0;
        if (jump) begin
          state_d = RISE;
          vel_d   = V0_V;
        end
      end
      RISE: begin
        y_n = y_s - signed'({6'b0, vel_q});
        if (y_n < YMIN_S) begin
          y_d     = Y_MIN_V;
          state_d = FALL;
          vel_d   = '0;
        end else begin
          y_d = y_n[9:0];
          if (vel_q <= G_V) begin
            state_d = FALL;
            vel_d   = '0;
          end else begin
            vel_d = vel_q - G_V;
          end
        end
      end
      FALL: begin
        y_n = y_s + signed'({6'b0, v_n});
        if (y_n >= YFLOOR_S) begin
          y_d     = Y_FLOOR_V;
          state_d = GROUND;
          vel_d   = '0;
        end else begin
          y_d   = y_n[9:0];
          vel_d = v_n;
        end
      end
      default: begin
        state_d = GROUND;
        y_d     = Y_FLOOR_V;
        vel_d   = '0;
      end
    endcase
  end

  // Respawn outranks the frame tick; vblnk_q keeps sampling even while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vblnk_q  <= 1'b0;
      x_q      <= X_INIT_V;
      y_q      <= Y_FLOOR_V;
      facing_q <= 1'b0;
      state_q  <= GROUND;
      vel_q    <= '0;
    end else begin
      vblnk_q <= vblnk;
      if (respawn) begin
        x_q      <= X_INIT_V;
        y_q      <= Y_FLOOR_V;
        facing_q <= 1'b0;
        state_q  <= GROUND;
        vel_q    <= '0;
      end else if (tick && en) begin
        x_q      <= x_d;
        y_q      <= y_d;
        facing_q <= facing_d;
        state_q  <= state_d;
        vel_q    <= vel_d;
      end
    end
  end

  assign jerry_x   = x_q;
  assign jerry_y   = y_q;
  assign facing    = facing_q;
  assign airborne  = (state_q != GROUND);
  assign dbg_state = state_q;
  assign dbg_vel   = vel_q;

endmodule
